// File: rtl/axis_pe_pkg.sv
// axis_pe_pkg: shared state encoding and result-word field positions for the PE sequencer.
package axis_pe_pkg;
  localparam int PE_W       = 8;
  localparam int Y_LSB      = 0;
  localparam int FORCED_BIT = 8;
  localparam int CNT_LSB    = 16;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;
endpackage

// File: rtl/axis_pe_seq_pe.sv
// pe: combinational multiply-accumulate cell, y_out = (y_in + a_in*b) mod 2^W; a_in is forwarded for chaining.
module pe #(
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b,
  input  logic [W-1:0] y_in,
  output logic [W-1:0] a_out,
  output logic [W-1:0] y_out
);
  logic [W-1:0] prod;
  assign prod  = SIGNED ? W'($signed(a_in) * $signed(b)) : W'(a_in * b);
  assign y_out = y_in + prod;
  assign a_out = a_in;
endmodule

// File: rtl/axis_pe_seq.sv
// axis_pe_seq: folds a tlast-delimited AXI-Stream of (a,b) pairs through one PE into a single result beat.
// Define AXIS_PE_SEQ_MAXLEN_EN to force group termination after MAX_BEATS beats.
module axis_pe_seq
  import axis_pe_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_BEATS = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        busy
);
  state_e            state_q, state_d;
  logic [PE_W-1:0]   acc_q, acc_d, y;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frc_q, frc_d, frc;

  pe #(PE_W, 1'b0) u_pe (
    .a_in (s_axis_tdata[7:0]),
    .b    (s_axis_tdata[15:8]),
    .y_in (acc_q),
    .a_out(),
    .y_out(y)
  );

`ifdef AXIS_PE_SEQ_MAXLEN_EN
  assign frc = !s_axis_tlast && (cnt_q + 1'b1 == CNT_W'(MAX_BEATS));
`else
  assign frc = 1'b0;
`endif

  assign s_axis_tready = state_q != OUT;
  assign m_axis_tvalid = state_q == OUT;
  assign m_axis_tlast  = m_axis_tvalid;
  assign busy          = state_q != IDLE;

  // acc/cnt/flag double as the output register: they are frozen while in OUT
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tdata[Y_LSB +: PE_W] = acc_q;
    m_axis_tdata[FORCED_BIT]    = frc_q;
    m_axis_tdata[CNT_LSB +: 16] = 16'(cnt_q);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    frc_d   = frc_q;
    if (state_q == OUT) begin
      if (m_axis_tready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        frc_d   = 1'b0;
      end
    end else if (s_axis_tvalid) begin
      acc_d   = y;
      cnt_d   = cnt_q + 1'b1;
      frc_d   = frc;
      state_d = (s_axis_tlast || frc) ? OUT : ACC;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      frc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      frc_q   <= frc_d;
    end
  end
endmodule

// File: tb/tb_axis_pe_seq.sv
// tb_axis_pe_seq: directed scoreboard bench for axis_pe_seq; inputs change at negedge+1, outputs sampled away from posedge.
module tb_axis_pe_seq;
  localparam int MB = 4;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        busy;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [7:0]  m_acc = '0;
  int          m_cnt = 0;

  axis_pe_seq #(.CNT_W(16), .MAX_BEATS(MB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  function automatic logic [31:0] res(input int cnt, input logic flag, input logic [7:0] y);
    return {16'(cnt), 7'b0, flag, y};
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    s_axis_tdata  = {16'hdead, b, a};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    while (!s_axis_tready && n < 50) begin
      step();
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_acc = 8'(m_acc + a * b);
    m_cnt++;
    if (last) begin
      sb.push_back(res(m_cnt, 1'b0, m_acc));
      m_acc = '0;
      m_cnt = 0;
    end
`ifdef AXIS_PE_SEQ_MAXLEN_EN
    else if (m_cnt == MB) begin
      sb.push_back(res(m_cnt, 1'b1, m_acc));
      m_acc = '0;
      m_cnt = 0;
    end
`endif
  endtask

  always begin
    @(negedge aclk);
    #3;
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL spurious_result observed=%h expected=none", m_axis_tdata);
      end else begin
        chk("result_tdata", m_axis_tdata, sb.pop_front());
        chk("result_tlast", 32'(m_axis_tlast), 32'd1);
      end
    end
  end

  initial begin
    int n;
    repeat (3) step();
    aresetn = 1'b1;
    step();
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    // basic dot product 3*4+5*6
    send(8'd3, 8'd4, 1'b0);
    chk("busy_acc", 32'(busy), 32'd1);
    send(8'd5, 8'd6, 1'b1);
    chk("latency_valid", 32'(m_axis_tvalid), 32'd1);
    chk("dot_tdata", m_axis_tdata, 32'h0002_002a);
    step();
    chk("post_hs_tready", 32'(s_axis_tready), 32'd1);
    chk("post_hs_valid", 32'(m_axis_tvalid), 32'd0);
    // wrap, then acc cleared
    send(8'd255, 8'd255, 1'b1);
    step();
    send(8'd2, 8'd2, 1'b1);
    step();
    // downstream stall with an input beat on offer
    m_axis_tready = 1'b0;
    send(8'd9, 8'd9, 1'b1);
    s_axis_tdata  = 32'h0000_0101;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_tdata", m_axis_tdata, res(1, 1'b0, 8'd81));
      chk("stall_tready", 32'(s_axis_tready), 32'd0);
      chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    step();
    chk("release_tready", 32'(s_axis_tready), 32'd1);
    chk("release_valid", 32'(m_axis_tvalid), 32'd0);
    // sparse tvalid
    for (int i = 0; i < 4; i++) begin
      send(8'd1, 8'd1, i == 3);
      if (i != 3) step();
    end
    chk("sparse_tdata", m_axis_tdata, res(4, 1'b0, 8'd4));
    step();
    // reset mid-group discards the partial result
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tdata", m_axis_tdata, 32'd0);
    chk("midrst_valid", 32'(m_axis_tvalid), 32'd0);
    m_acc = '0;
    m_cnt = 0;
    step();
    aresetn = 1'b1;
    step();
    send(8'd7, 8'd3, 1'b1);
    chk("fresh_tdata", m_axis_tdata, res(1, 1'b0, 8'd21));
    step();
    // six-beat group: forced split only when the length limit is built in
    for (int i = 0; i < 6; i++) send(8'd1, 8'd1, i == 5);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
    repeat (2) step();
    chk("end_idle", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
